// File: rtl/ddr3_req_arbiter.sv
// ddr3_req_arbiter: shares the DDR3 app command port between queued writes and a read slot.
// Optional read-starvation guard enabled with `define DDR_ARB_FAIRNESS_EN.
module ddr3_req_arbiter #(
  parameter int IN_ADDR_W     = 16,
  parameter int APP_ADDR_W    = 28,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int STARVE_MAX    = 8
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_calib_done,
  input  logic                  I_wr_en,
  input  logic [IN_ADDR_W-1:0]  I_wr_addr,
  input  logic [47:0]           I_wr_data,
  input  logic                  I_rd_en,
  input  logic [IN_ADDR_W-1:0]  I_rd_addr,
  input  logic                  I_app_rdy,
  input  logic                  I_app_wdf_rdy,
  output logic                  O_app_en,
  output logic [2:0]            O_app_cmd,
  output logic [APP_ADDR_W-1:0] O_app_addr,
  output logic                  O_app_wdf_wren,
  output logic                  O_app_wdf_end,
  output logic [63:0]           O_app_wdf_data,
  output logic [7:0]            O_app_wdf_mask,
  output logic                  O_wr_ovf,
  output logic                  O_rd_ovf,
  output logic                  O_busy
);

  localparam int PW = $clog2(WR_FIFO_DEPTH);
  localparam int EW = IN_ADDR_W + 48;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WR_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t state_q, state_d;

  logic                 wstg_v_q;
  logic [IN_ADDR_W-1:0] wstg_a_q;
  logic [47:0]          wstg_d_q;
  logic                 rstg_v_q;
  logic [IN_ADDR_W-1:0] rstg_a_q;

  logic [EW-1:0]        mem_q [WR_FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [PW:0]          cnt_q;

  logic                 slot_v_q;
  logic [IN_ADDR_W-1:0] slot_a_q;
  logic                 wr_ovf_q, rd_ovf_q, busy_q;

  logic                  en_q, en_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [APP_ADDR_W-1:0] addr_q, addr_d;
  logic                  wren_q, wren_d;
  logic [63:0]           data_q, data_d;
  logic [7:0]            mask_q, mask_d;

  logic [IN_ADDR_W-1:0] head_addr;
  logic [47:0]          head_data;
  logic full, wr_acc, rd_acc, push, pop, fill;
  logic grant_wr, grant_rd, starve;

  assign {head_addr, head_data} = mem_q[rptr_q];
  assign full   = (cnt_q == FULL_CNT);
  assign wr_acc = (state_q == S_WR) & I_app_rdy & I_app_wdf_rdy;
  assign rd_acc = (state_q == S_RD) & I_app_rdy;
  assign pop    = wr_acc;
  assign push   = wstg_v_q & (~full | wr_acc);
  assign fill   = rstg_v_q & (~slot_v_q | rd_acc);

`ifdef DDR_ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;

  assign starve = (starve_q >= SW'(STARVE_MAX));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      starve_q <= '0;
    end else if (grant_rd || !slot_v_q) begin
      starve_q <= '0;
    end else if (grant_wr && !starve) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (I_calib_done) begin
          if (starve && slot_v_q) begin
            grant_rd = 1'b1;
          end else if (cnt_q != '0) begin
            grant_wr = 1'b1;
          end else if (slot_v_q) begin
            grant_rd = 1'b1;
          end
        end
        if (grant_wr) state_d = S_WR;
        if (grant_rd) state_d = S_RD;
      end
      S_WR:    if (wr_acc) state_d = S_IDLE;
      S_RD:    if (rd_acc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs follow the next state so the bus drops on the accepting edge.
  always_comb begin
    en_d   = 1'b0;
    cmd_d  = 3'b000;
    addr_d = '0;
    wren_d = 1'b0;
    data_d = '0;
    mask_d = 8'h00;
    unique case (state_d)
      S_WR: begin
        en_d   = 1'b1;
        addr_d = APP_ADDR_W'(head_addr) << 3;
        wren_d = 1'b1;
        data_d = {16'h0000, head_data};
        mask_d = 8'hC0;
      end
      S_RD: begin
        en_d   = 1'b1;
        cmd_d  = 3'b001;
        addr_d = APP_ADDR_W'(slot_a_q) << 3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wstg_v_q <= 1'b0;
      wstg_a_q <= '0;
      wstg_d_q <= '0;
      rstg_v_q <= 1'b0;
      rstg_a_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      slot_v_q <= 1'b0;
      slot_a_q <= '0;
      wr_ovf_q <= 1'b0;
      rd_ovf_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < WR_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wstg_v_q <= I_wr_en;
      wstg_a_q <= I_wr_addr;
      wstg_d_q <= I_wr_data;
      rstg_v_q <= I_rd_en;
      rstg_a_q <= I_rd_addr;
      if (push) begin
        mem_q[wptr_q] <= {wstg_a_q, wstg_d_q};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (wstg_v_q && !push) wr_ovf_q <= 1'b1;
      if (fill) begin
        slot_v_q <= 1'b1;
        slot_a_q <= rstg_a_q;
      end else if (rd_acc) begin
        slot_v_q <= 1'b0;
      end
      if (rstg_v_q && !fill) rd_ovf_q <= 1'b1;
      busy_q <= (cnt_q != '0) | slot_v_q | (state_q != S_IDLE)
              | wstg_v_q | rstg_v_q;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      en_q   <= 1'b0;
      cmd_q  <= 3'b000;
      addr_q <= '0;
      wren_q <= 1'b0;
      data_q <= '0;
      mask_q <= 8'h00;
    end else begin
      en_q   <= en_d;
      cmd_q  <= cmd_d;
      addr_q <= addr_d;
      wren_q <= wren_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign O_app_en       = en_q;
  assign O_app_cmd      = cmd_q;
  assign O_app_addr     = addr_q;
  assign O_app_wdf_wren = wren_q;
  assign O_app_wdf_end  = wren_q;
  assign O_app_wdf_data = data_q;
  assign O_app_wdf_mask = mask_q;
  assign O_wr_ovf       = wr_ovf_q;
  assign O_rd_ovf       = rd_ovf_q;
  assign O_busy         = busy_q;

endmodule
